ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu_pkg.sv | 14 +
 rtl/ifu_if.sv | 49 ++++
 rtl/ifu.sv | 83 ++++++++
 tb/tb_ifu.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared IFU definitions: FSM state encoding and instruction size.
package ifu_pkg;

   // Fixed instruction size in bytes; sequential PC advance.
   localparam int ILEN = 4;

   // FSM state type and its legacy-compatible encodings.
   typedef logic [1:0] ifu_state_e;
   localparam ifu_state_e S_IDLE = 2'd0;
   localparam ifu_state_e S_REQ  = 2'd1;
   localparam ifu_state_e S_RSP  = 2'd2;
   localparam ifu_state_e S_EXEC = 2'd3;

endpackage

// File: rtl/ifu_if.sv
// Fetch and execute channels used by the IFU.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where both vld and rdy are high. Once vld is raised it stays high, with its
// payload unchanged, until that transfer; rdy may change freely.

// Instruction fetch: request carries the PC, response returns the word.
interface ifetch_if_t #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req_vld;
   logic          req_rdy;
   logic [AW-1:0] req_pc;
   logic          rsp_vld;
   logic          rsp_rdy;
   logic [DW-1:0] rsp_ir;

   modport master (output req_vld, req_pc, rsp_rdy,
                   input  req_rdy, rsp_vld, rsp_ir);
   modport slave  (input  req_vld, req_pc, rsp_rdy,
                   output req_rdy, rsp_vld, rsp_ir);
endinterface

// Instruction issue: the branch outcome in rsp_pkt is valid in the accept cycle.
interface iexec_if_t #(
   parameter int AW = 32,
   parameter int DW = 32
);
   typedef struct packed {
      logic [DW-1:0] ir;
      logic [AW-1:0] pc;
   } req_pkt_t;

   typedef struct packed {
      logic          taken;
      logic [DW-1:0] offset;
   } rsp_pkt_t;

   logic     req_vld;
   logic     req_rdy;
   req_pkt_t req_pkt;
   rsp_pkt_t rsp_pkt;

   modport master (output req_vld, req_pkt,
                   input  req_rdy, rsp_pkt);
   modport slave  (input  req_vld, req_pkt,
                   output req_rdy, rsp_pkt);
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: fetch one instruction, issue it, then advance the PC
// using the branch outcome returned in the issue cycle. One instruction in flight.
module ifu
   import ifu_pkg::*;
#(
   parameter int            AW       = 32,
   parameter int            DW       = 32,
   parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        halt,
   ifetch_if_t.master  fetch,
   iexec_if_t.master   exec,
   output logic [63:0] instret,
   output logic        busy,
   output ifu_state_e  state
);

   ifu_state_e    state_q;
   ifu_state_e    state_d;
   logic [AW-1:0] pc_q;
   logic [AW-1:0] pc_next;
   logic [DW-1:0] ir_q;
   logic          fetch_acc;
   logic          rsp_acc;
   logic          exec_acc;

   // Handshake completions are qualified by state, so a stray rsp_vld is ignored.
   assign fetch_acc = (state_q == S_REQ)  && fetch.req_rdy;
   assign rsp_acc   = (state_q == S_RSP)  && fetch.rsp_vld;
   assign exec_acc  = (state_q == S_EXEC) && exec.req_rdy;

   // Next PC: modular add, so negative offsets and wrap-around need no special case.
   always_comb begin
      pc_next = pc_q + AW'(ILEN);
      if (exec.rsp_pkt.taken) begin
         pc_next = pc_q + exec.rsp_pkt.offset[AW-1:0];
      end
   end

   // Next-state: halt is only consulted when idle or after an issue completes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!halt)    state_d = S_REQ;
         S_REQ:   if (fetch_acc) state_d = S_RSP;
         S_RSP:   if (rsp_acc)   state_d = S_EXEC;
         S_EXEC:  if (exec_acc)  state_d = halt ? S_IDLE : S_REQ;
         default:               state_d = S_IDLE;
      endcase
   end

   // State, PC, instruction register and retired count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         instret <= '0;
      end else begin
         state_q <= state_d;
         if (rsp_acc) begin
            ir_q <= fetch.rsp_ir;
         end
         if (exec_acc) begin
            pc_q    <= pc_next;
            instret <= instret + 64'd1;
         end
      end
   end

   // Moore outputs: valids and readies decode straight from the state register,
   // so they cannot retract and drop at once on reset.
   assign fetch.req_vld = (state_q == S_REQ);
   assign fetch.req_pc  = pc_q;
   assign fetch.rsp_rdy = (state_q == S_RSP);
   assign exec.req_vld  = (state_q == S_EXEC);
   assign exec.req_pkt  = {ir_q, pc_q};
   assign busy          = (state_q != S_IDLE);
   assign state         = state_q;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed phases push expected fetch PCs and issue packets into
// queues; a monitor pops and compares on every handshake.
module tb_ifu;
   import ifu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        halt;
   logic [63:0] instret;
   logic        busy;
   ifu_state_e  state;

   logic        w_halt;
   logic [63:0] w_instret;
   logic        w_busy;
   ifu_state_e  w_state;

   ifetch_if_t #(.AW(32), .DW(32)) f_if ();
   iexec_if_t  #(.AW(32), .DW(32)) e_if ();
   ifetch_if_t #(.AW(32), .DW(32)) wf_if ();
   iexec_if_t  #(.AW(32), .DW(32)) we_if ();

   ifu #(.AW(32), .DW(32), .RESET_PC(32'h0000_0000)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .halt    (halt),
      .fetch   (f_if),
      .exec    (e_if),
      .instret (instret),
      .busy    (busy),
      .state   (state)
   );

   ifu #(.AW(32), .DW(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk     (clk),
      .rst_n   (rst_n),
      .halt    (w_halt),
      .fetch   (wf_if),
      .exec    (we_if),
      .instret (w_instret),
      .busy    (w_busy),
      .state   (w_state)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] fetch_q[$];
   logic [63:0] exec_q[$];
   logic [31:0] w_q[$];
   logic [32:0] br_q[$];

   logic        pf_hold;
   logic [31:0] pf_pc;
   logic        pe_hold;
   logic [63:0] pe_pkt;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ir_of(input logic [31:0] pc);
      return pc ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic push_insn(input logic [31:0] pc);
      fetch_q.push_back(pc);
      exec_q.push_back({ir_of(pc), pc});
   endtask

   // Fetch memory model: answers in the cycle after the request is taken.
   initial begin
      f_if.rsp_vld = 1'b0;
      f_if.rsp_ir  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) f_if.rsp_vld = 1'b0;
         else if (f_if.rsp_rdy && !f_if.rsp_vld) begin
            f_if.rsp_vld = 1'b1;
            f_if.rsp_ir  = ir_of(f_if.req_pc);
         end else if (!f_if.rsp_rdy && f_if.rsp_vld) f_if.rsp_vld = 1'b0;
      end
   end

   // Second instance: free-running, rsp_vld held high even outside S_RSP.
   initial begin
      w_halt         = 1'b0;
      wf_if.req_rdy  = 1'b1;
      wf_if.rsp_vld  = 1'b1;
      wf_if.rsp_ir   = 32'h0000_0013;
      we_if.req_rdy  = 1'b1;
      we_if.rsp_pkt  = '0;
   end

   // Monitor: sampled mid-low-phase, after the driver has updated inputs.
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         pf_hold = 1'b0;
         pe_hold = 1'b0;
      end else begin
         if (pf_hold) begin
            check("fetch_hold_vld", 64'(f_if.req_vld), 64'd1);
            check("fetch_hold_pc", 64'(f_if.req_pc), 64'(pf_pc));
         end
         if (pe_hold) begin
            check("exec_hold_vld", 64'(e_if.req_vld), 64'd1);
            check("exec_hold_pkt", e_if.req_pkt, pe_pkt);
         end
         if (f_if.req_vld && f_if.req_rdy) begin
            if (fetch_q.size() == 0) check("fetch_unexpected", 64'(f_if.req_pc), 64'hDEAD);
            else check("fetch_pc", 64'(f_if.req_pc), 64'(fetch_q.pop_front()));
         end
         if (e_if.req_vld && e_if.req_rdy) begin
            if (exec_q.size() == 0) check("exec_unexpected", e_if.req_pkt, 64'hDEAD);
            else check("exec_pkt", e_if.req_pkt, exec_q.pop_front());
         end
         if (wf_if.req_vld && wf_if.req_rdy && w_q.size() > 0)
            check("wrap_fetch_pc", 64'(wf_if.req_pc), 64'(w_q.pop_front()));
         pf_hold = f_if.req_vld && !f_if.req_rdy;
         pf_pc   = f_if.req_pc;
         pe_hold = e_if.req_vld && !e_if.req_rdy;
         pe_pkt  = e_if.req_pkt;
      end
   end

   // Driver: step to n issue accepts, supplying branch outcomes from br_q.
   task automatic run_accepts(input int n, input logic stop_after);
      int k = 0;
      int cyc = 0;
      while (k < n && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (e_if.req_vld) e_if.rsp_pkt = (br_q.size() > 0) ? br_q[0] : 33'd0;
         if (e_if.req_vld && e_if.req_rdy) begin
            k++;
            if (br_q.size() > 0) void'(br_q.pop_front());
            if (k == n && stop_after) halt = 1'b1;
         end
      end
      if (k < n) check("accept_timeout", 64'(k), 64'(n));
   endtask

   // Driver: wait (bounded) for fetch req_vld (0), exec req_vld (1) or rsp_rdy (2).
   task automatic wait_sig(input int which);
      int cyc = 0;
      logic hit = 1'b0;
      while (!hit && cyc < 100) begin
         @(negedge clk);
         cyc++;
         case (which)
            0:       hit = f_if.req_vld;
            1:       hit = e_if.req_vld;
            default: hit = f_if.rsp_rdy;
         endcase
      end
      if (!hit) check("wait_timeout", 64'(which), 64'hFF);
   endtask

   initial begin
      rst_n         = 1'b1;
      halt          = 1'b0;
      f_if.req_rdy  = 1'b1;
      e_if.req_rdy  = 1'b1;
      e_if.rsp_pkt  = '0;
      pf_hold       = 1'b0;
      pe_hold       = 1'b0;
      pf_pc         = '0;
      pe_pkt        = '0;
      #2 rst_n = 1'b0;

      // Reset values while rst_n is low.
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_fetch_vld", 64'(f_if.req_vld), 64'd0);
      check("rst_rsp_rdy", 64'(f_if.rsp_rdy), 64'd0);
      check("rst_exec_vld", 64'(e_if.req_vld), 64'd0);
      check("rst_instret", instret, 64'd0);
      check("rst_state", 64'(state), 64'(S_IDLE));

      // Sequential fetch 0,4,8.
      push_insn(32'h0); push_insn(32'h4); push_insn(32'h8);
      w_q.push_back(32'hFFFF_FFFC); w_q.push_back(32'h0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      run_accepts(3, 1'b1);
      @(negedge clk);
      check("seq_instret", instret, 64'd3);
      check("seq_idle", 64'(busy), 64'd0);

      // Branches: 0xC falls through to 0x10, then -8 to 0x08, then +0x100.
      push_insn(32'hC); push_insn(32'h10); push_insn(32'h8);
      br_q.push_back({1'b0, 32'h0});
      br_q.push_back({1'b1, 32'hFFFF_FFF8});
      br_q.push_back({1'b1, 32'h0000_0100});
      halt = 1'b0;
      run_accepts(3, 1'b1);
      @(negedge clk);
      check("br_instret", instret, 64'd6);

      // Back-pressure on both channels at pc 0x108.
      push_insn(32'h108);
      e_if.rsp_pkt = '0;
      f_if.req_rdy = 1'b0;
      e_if.req_rdy = 1'b0;
      halt = 1'b0;
      wait_sig(0);
      repeat (5) begin
         check("bp_fetch_pc", 64'(f_if.req_pc), 64'h108);
         check("bp_fetch_instret", instret, 64'd6);
         @(negedge clk);
      end
      f_if.req_rdy = 1'b1;
      wait_sig(1);
      repeat (3) begin
         check("bp_exec_pkt", e_if.req_pkt, {ir_of(32'h108), 32'h108});
         check("bp_exec_instret", instret, 64'd6);
         @(negedge clk);
      end
      e_if.req_rdy = 1'b1;
      halt = 1'b1;
      @(negedge clk);
      check("bp_instret", instret, 64'd7);
      check("bp_idle", 64'(busy), 64'd0);

      // halt raised in S_RSP: instruction still completes, then idle.
      push_insn(32'h10C);
      halt = 1'b0;
      wait_sig(2);
      halt = 1'b1;
      run_accepts(1, 1'b1);
      @(negedge clk);
      check("halt_instret", instret, 64'd8);
      check("halt_busy", 64'(busy), 64'd0);
      check("halt_state", 64'(state), 64'(S_IDLE));
      repeat (4) begin
         @(negedge clk);
         check("halt_no_fetch", 64'(f_if.req_vld), 64'd0);
      end

      // Reset pulse while in S_EXEC: issue dropped, restart at RESET_PC.
      fetch_q.push_back(32'h110);
      e_if.req_rdy = 1'b0;
      halt = 1'b0;
      wait_sig(1);
      #3 rst_n = 1'b0;
      #1;
      check("rstx_exec_vld", 64'(e_if.req_vld), 64'd0);
      check("rstx_instret", instret, 64'd0);
      check("rstx_busy", 64'(busy), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      e_if.req_rdy = 1'b1;
      push_insn(32'h0);
      run_accepts(1, 1'b1);
      @(negedge clk);
      check("rstx_instret_after", instret, 64'd1);

      check("fetch_q_empty", 64'(fetch_q.size()), 64'd0);
      check("exec_q_empty", 64'(exec_q.size()), 64'd0);
      check("wrap_q_empty", 64'(w_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
